// File: rtl/video_mode_pkg.sv
// Mode encodings for the video mux selects and the helpers that step
// them when a button press arrives.
package video_mode_pkg;

  typedef enum logic [1:0] {
    BG_CAMERA  = 2'b00,
    BG_CHANNEL = 2'b01,
    BG_THRESH  = 2'b10,
    BG_YMASK   = 2'b11
  } bg_mode_t;

  typedef enum logic [1:0] {
    TGT_NONE      = 2'b00,
    TGT_CROSSHAIR = 2'b01,
    TGT_SPRITE    = 2'b10,
    TGT_TEST      = 2'b11
  } tgt_mode_t;

  function automatic bg_mode_t next_bg(input bg_mode_t cur);
    logic [1:0] v;
    v = cur;
    v = v + 2'd1;
    return bg_mode_t'(v);
  endfunction

  // With the test colour skipped, both SPRITE and TEST (reachable only via override) wrap to NONE.
  function automatic tgt_mode_t next_tgt(input tgt_mode_t cur, input logic skip_test);
    logic [1:0] v;
    v = cur;
    if (skip_test && (cur == TGT_SPRITE || cur == TGT_TEST)) begin
      v = 2'd0;
    end else begin
      v = v + 2'd1;
    end
    return tgt_mode_t'(v);
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchronizes a raw button, debounces it by requiring a run of stable
// differing samples, and emits a one-cycle pulse on each accepted press.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 200000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_level,
  output logic o_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_meta;
  logic          r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_press;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_meta  <= i_btn;
      r_sync  <= r_meta;
      r_press <= 1'b0;
      if (r_sync == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        // Only a rising accepted level counts as a press; releases are silent.
        r_cnt   <= '0;
        r_level <= r_sync;
        r_press <= r_sync;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;

endmodule

// File: rtl/video_mode_ctrl.sv
// Collects button presses and overrides into pending modes and commits them
// to the video mux selects only at frame start.
module video_mode_ctrl
  import video_mode_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 200000,
  parameter int SKIP_TEST_COLOR = 1
) (
  input  logic       clk_in,
  input  logic       rst_in_n,
  input  logic       btn_bg_in,
  input  logic       btn_tgt_in,
  input  logic       frame_start_in,
  input  logic       override_valid_in,
  input  logic [1:0] override_bg_in,
  input  logic [1:0] override_tgt_in,
  output logic [1:0] background_choice_out,
  output logic [1:0] target_choice_out,
  output logic       pending_out,
  output logic       mode_changed_out
);

  localparam logic SKIP = (SKIP_TEST_COLOR != 0);

  logic      w_bg_press;
  logic      w_tgt_press;
  logic      w_bg_level;
  logic      w_tgt_level;
  logic      w_pending;
  bg_mode_t  w_pend_bg_nxt;
  tgt_mode_t w_pend_tgt_nxt;

  bg_mode_t  r_pend_bg;
  tgt_mode_t r_pend_tgt;
  bg_mode_t  r_bg_out;
  tgt_mode_t r_tgt_out;
  logic      r_changed;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bg_debounce (
    .i_clk   (clk_in),
    .i_rst_n (rst_in_n),
    .i_btn   (btn_bg_in),
    .o_level (w_bg_level),
    .o_press (w_bg_press)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_tgt_debounce (
    .i_clk   (clk_in),
    .i_rst_n (rst_in_n),
    .i_btn   (btn_tgt_in),
    .o_level (w_tgt_level),
    .o_press (w_tgt_press)
  );

  // An override in the same cycle as a press wins and the press is dropped.
  always_comb begin
    w_pend_bg_nxt  = r_pend_bg;
    w_pend_tgt_nxt = r_pend_tgt;
    if (override_valid_in) begin
      w_pend_bg_nxt  = bg_mode_t'(override_bg_in);
      w_pend_tgt_nxt = tgt_mode_t'(override_tgt_in);
    end else begin
      if (w_bg_press) begin
        w_pend_bg_nxt = next_bg(r_pend_bg);
      end
      if (w_tgt_press) begin
        w_pend_tgt_nxt = next_tgt(r_pend_tgt, SKIP);
      end
    end
  end

  assign w_pending = (r_pend_bg != r_bg_out) || (r_pend_tgt != r_tgt_out);

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      r_pend_bg  <= BG_CAMERA;
      r_pend_tgt <= TGT_NONE;
      r_bg_out   <= BG_CAMERA;
      r_tgt_out  <= TGT_NONE;
      r_changed  <= 1'b0;
    end else begin
      r_pend_bg  <= w_pend_bg_nxt;
      r_pend_tgt <= w_pend_tgt_nxt;
      r_changed  <= 1'b0;
      // Commit samples the pending values from before this edge, so a
      // coincident press or override lands at the following frame.
      if (frame_start_in) begin
        r_bg_out  <= r_pend_bg;
        r_tgt_out <= r_pend_tgt;
        r_changed <= w_pending;
      end
    end
  end

  assign background_choice_out = r_bg_out;
  assign target_choice_out     = r_tgt_out;
  assign pending_out           = w_pending;
  assign mode_changed_out      = r_changed;

endmodule

// File: tb/tb_video_mode_ctrl.sv
// Directed bench for video_mode_ctrl with a short debounce window and the
// test colour skipped during target cycling.
module tb_video_mode_ctrl;

  logic       clk_in = 1'b0;
  logic       rst_in_n = 1'b0;
  logic       btn_bg_in = 1'b0;
  logic       btn_tgt_in = 1'b0;
  logic       frame_start_in = 1'b0;
  logic       override_valid_in = 1'b0;
  logic [1:0] override_bg_in = 2'b00;
  logic [1:0] override_tgt_in = 2'b00;
  logic [1:0] background_choice_out;
  logic [1:0] target_choice_out;
  logic       pending_out;
  logic       mode_changed_out;

  int checks = 0;
  int errors = 0;

  video_mode_ctrl #(.DEBOUNCE_CYCLES(4), .SKIP_TEST_COLOR(1)) dut (
    .clk_in                (clk_in),
    .rst_in_n              (rst_in_n),
    .btn_bg_in             (btn_bg_in),
    .btn_tgt_in            (btn_tgt_in),
    .frame_start_in        (frame_start_in),
    .override_valid_in     (override_valid_in),
    .override_bg_in        (override_bg_in),
    .override_tgt_in       (override_tgt_in),
    .background_choice_out (background_choice_out),
    .target_choice_out     (target_choice_out),
    .pending_out           (pending_out),
    .mode_changed_out      (mode_changed_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    btn_bg_in = 0; btn_tgt_in = 0; frame_start_in = 0;
    override_valid_in = 0; override_bg_in = 0; override_tgt_in = 0;
    rst_in_n = 0;
    tick(); tick();
    rst_in_n = 1;
    tick();
  endtask

  task automatic press(input bit is_bg);
    if (is_bg) btn_bg_in = 1; else btn_tgt_in = 1;
    repeat (12) tick();
    if (is_bg) btn_bg_in = 0; else btn_tgt_in = 0;
    repeat (12) tick();
  endtask

  task automatic commit();
    frame_start_in = 1;
    tick();
    frame_start_in = 0;
  endtask

  task automatic test_reset();
    rst_in_n = 0;
    tick(); tick();
    checks++; if (background_choice_out !== 2'b00) begin errors++; $display("[TB] FAIL reset_bg got %b want 00", background_choice_out); end
    checks++; if (target_choice_out !== 2'b00) begin errors++; $display("[TB] FAIL reset_tgt got %b want 00", target_choice_out); end
    checks++; if (pending_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_pending got %b want 0", pending_out); end
    checks++; if (mode_changed_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_changed got %b want 0", mode_changed_out); end
    rst_in_n = 1;
    tick();
  endtask

  task automatic test_clean_bg_press();
    btn_bg_in = 1;
    repeat (20) tick();
    checks++; if (pending_out !== 1'b1) begin errors++; $display("[TB] FAIL clean_pending got %b want 1", pending_out); end
    checks++; if (background_choice_out !== 2'b00) begin errors++; $display("[TB] FAIL clean_bg_precommit got %b want 00", background_choice_out); end
    btn_bg_in = 0;
    repeat (12) tick();
    commit();
    checks++; if (background_choice_out !== 2'b01) begin errors++; $display("[TB] FAIL clean_bg_commit got %b want 01", background_choice_out); end
    checks++; if (target_choice_out !== 2'b00) begin errors++; $display("[TB] FAIL clean_tgt_commit got %b want 00", target_choice_out); end
    checks++; if (mode_changed_out !== 1'b1) begin errors++; $display("[TB] FAIL clean_changed_pulse got %b want 1", mode_changed_out); end
    tick();
    checks++; if (mode_changed_out !== 1'b0) begin errors++; $display("[TB] FAIL clean_changed_end got %b want 0", mode_changed_out); end
    checks++; if (pending_out !== 1'b0) begin errors++; $display("[TB] FAIL clean_pending_clear got %b want 0", pending_out); end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 6; i++) begin
      btn_tgt_in = (i % 2 == 0);
      repeat (2) tick();
    end
    btn_tgt_in = 1;
    repeat (20) tick();
    btn_tgt_in = 0;
    repeat (12) tick();
    commit();
    checks++; if (target_choice_out !== 2'b01) begin errors++; $display("[TB] FAIL bounce_tgt got %b want 01", target_choice_out); end
    checks++; if (background_choice_out !== 2'b01) begin errors++; $display("[TB] FAIL bounce_bg got %b want 01", background_choice_out); end
    checks++; if (mode_changed_out !== 1'b1) begin errors++; $display("[TB] FAIL bounce_changed got %b want 1", mode_changed_out); end
  endtask

  task automatic test_target_cycle();
    logic [1:0] expTgt [3];
    expTgt = '{2'b01, 2'b10, 2'b00};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      press(1'b0);
      commit();
      checks++; if (target_choice_out !== expTgt[i]) begin errors++; $display("[TB] FAIL cycle_tgt%0d got %b want %b", i, target_choice_out, expTgt[i]); end
      checks++; if (mode_changed_out !== 1'b1) begin errors++; $display("[TB] FAIL cycle_changed%0d got %b want 1", i, mode_changed_out); end
    end
  endtask

  task automatic test_override_priority();
    bit seen;
    do_reset();
    press(1'b1);
    commit();
    checks++; if (background_choice_out !== 2'b01) begin errors++; $display("[TB] FAIL ovr_setup_bg got %b want 01", background_choice_out); end
    btn_bg_in = 1;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick();
      if (dut.u_bg_debounce.o_press === 1'b1) seen = 1;
    end
    checks++; if (!seen) begin errors++; $display("[TB] FAIL ovr_press_wait got timeout want press event"); end
    override_valid_in = 1; override_bg_in = 2'b11; override_tgt_in = 2'b10; frame_start_in = 1;
    tick();
    override_valid_in = 0; override_bg_in = 0; override_tgt_in = 0; frame_start_in = 0;
    checks++; if (background_choice_out !== 2'b01) begin errors++; $display("[TB] FAIL ovr_old_bg got %b want 01", background_choice_out); end
    checks++; if (target_choice_out !== 2'b00) begin errors++; $display("[TB] FAIL ovr_old_tgt got %b want 00", target_choice_out); end
    checks++; if (mode_changed_out !== 1'b0) begin errors++; $display("[TB] FAIL ovr_no_change got %b want 0", mode_changed_out); end
    checks++; if (pending_out !== 1'b1) begin errors++; $display("[TB] FAIL ovr_pending got %b want 1", pending_out); end
    btn_bg_in = 0;
    repeat (12) tick();
    commit();
    checks++; if (background_choice_out !== 2'b11) begin errors++; $display("[TB] FAIL ovr_new_bg got %b want 11", background_choice_out); end
    checks++; if (target_choice_out !== 2'b10) begin errors++; $display("[TB] FAIL ovr_new_tgt got %b want 10", target_choice_out); end
    checks++; if (mode_changed_out !== 1'b1) begin errors++; $display("[TB] FAIL ovr_changed got %b want 1", mode_changed_out); end
  endtask

  task automatic test_skip_from_test_color();
    override_valid_in = 1; override_bg_in = 2'b11; override_tgt_in = 2'b11;
    tick();
    override_valid_in = 0; override_bg_in = 0; override_tgt_in = 0;
    commit();
    checks++; if (target_choice_out !== 2'b11) begin errors++; $display("[TB] FAIL skip_loaded got %b want 11", target_choice_out); end
    press(1'b0);
    commit();
    checks++; if (target_choice_out !== 2'b00) begin errors++; $display("[TB] FAIL skip_wrap got %b want 00", target_choice_out); end
    checks++; if (background_choice_out !== 2'b11) begin errors++; $display("[TB] FAIL skip_bg_kept got %b want 11", background_choice_out); end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    press(1'b1);
    commit();
    press(1'b1);
    press(1'b0);
    checks++; if (pending_out !== 1'b1) begin errors++; $display("[TB] FAIL mid_pending got %b want 1", pending_out); end
    @(negedge clk_in);
    rst_in_n = 0;
    #1;
    checks++; if (background_choice_out !== 2'b00) begin errors++; $display("[TB] FAIL mid_rst_bg got %b want 00", background_choice_out); end
    checks++; if (target_choice_out !== 2'b00) begin errors++; $display("[TB] FAIL mid_rst_tgt got %b want 00", target_choice_out); end
    checks++; if (pending_out !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_pending got %b want 0", pending_out); end
    tick();
    rst_in_n = 1;
    tick();
    commit();
    checks++; if (background_choice_out !== 2'b00) begin errors++; $display("[TB] FAIL mid_after_bg got %b want 00", background_choice_out); end
    checks++; if (target_choice_out !== 2'b00) begin errors++; $display("[TB] FAIL mid_after_tgt got %b want 00", target_choice_out); end
    checks++; if (mode_changed_out !== 1'b0) begin errors++; $display("[TB] FAIL mid_after_changed got %b want 0", mode_changed_out); end
  endtask

  task automatic test_held_through_reset();
    rst_in_n = 0;
    btn_bg_in = 1;
    tick(); tick();
    rst_in_n = 1;
    repeat (20) tick();
    btn_bg_in = 0;
    repeat (12) tick();
    commit();
    checks++; if (background_choice_out !== 2'b01) begin errors++; $display("[TB] FAIL held_bg got %b want 01", background_choice_out); end
  endtask

  initial begin
    test_reset();
    test_clean_bg_press();
    test_bounce();
    test_target_cycle();
    test_override_priority();
    test_skip_from_test_color();
    test_reset_mid_frame();
    test_held_through_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
